line_buffer_3x3: RTL and testbench
==================================

LINE_BUFFER_3X3 -- requirements
Module: line_buffer_3x3

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 4: pixels per line; legal range 3..1024.
REQ-002 SHALL have parameter IMG_HEIGHT, default 4: lines per frame; legal range 3..1024.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_pix is accepted this cycle; there is no backpressure.
REQ-006 SHALL have port in_sof, input, 1 bit: start of frame, qualified by in_valid.
REQ-007 SHALL have port in_pix, input, 8 bits: raster-order pixel.
REQ-008 SHALL have port win, output, 72 bits: 3x3 window, element (r,c) at bits [(3*r+c)*8 +: 8], p00 at [7:0], p22 at [71:64].
REQ-009 SHALL have port win_valid, output, 1 bit: win holds a complete in-image window.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame.

Function
REQ-011 SHALL track col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) of the next accepted pixel; cycles with in_valid=0 change no state.
REQ-012 SHALL on an accepted pixel advance col; at col=IMG_WIDTH-1 wrap col to 0 and increment row.
REQ-013 SHALL keep two line delays of IMG_WIDTH pixels each, holding the previous two lines and indexed by col.
REQ-014 SHALL on an accepted pixel at (row,col) shift the window left one column and insert the new right column {line(row-2,col), line(row-1,col), in_pix} as rows 0,1,2.
REQ-015 SHALL make win p00 = pixel(row-2,col-2) and p22 = pixel(row,col) for the pixel that completes the window.
REQ-016 SHALL assert win_valid for exactly one cycle, 1 cycle after acceptance of a pixel with row>=2 and col>=2; otherwise win_valid=0.
REQ-017 SHALL hold win stable while win_valid=0.
REQ-018 SHALL produce (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame, with no windows spanning a line wrap.
REQ-019 SHALL run a state machine with two states: FILL (row<2, win_valid suppressed) and STREAM (row>=2). FILL->STREAM on acceptance of pixel (1,IMG_WIDTH-1). STREAM->FILL on acceptance of pixel (IMG_HEIGHT-1,IMG_WIDTH-1).
REQ-020 SHALL pulse frame_done 1 cycle after acceptance of pixel (IMG_HEIGHT-1,IMG_WIDTH-1), coincident with that pixel's win_valid, and then wrap row and col to 0.
REQ-021 SHALL on in_valid=1 with in_sof=1 treat in_pix as pixel (0,0) regardless of the current counters and enter FILL; an aborted frame produces no frame_done.
REQ-022 SHALL treat in_sof with in_valid=0 as don't-care.

Reset
REQ-023 SHALL on rst=1 asynchronously clear row, col, the state (to FILL), win (to 0), win_valid (to 0) and frame_done (to 0).
REQ-024 SHALL not reset line delay storage; stale contents never reach a valid window, because FILL refills both lines.
REQ-025 SHALL accept the first pixel after rst deasserts as (0,0) without requiring in_sof.

Configuration
REQ-026 SHALL support macro LINE_BUFFER_OUT_REG_EN. When defined: add one output register stage on win, win_valid and frame_done, giving 2-cycle latency. When undefined: 1-cycle latency per REQ-016/020.

Structure
REQ-027 SHALL take PIX_W=8, KSIZE=3 and the window bit-index helper from shared package conv_pkg, which the convolution stage also uses.
REQ-028 SHALL implement each line delay as one instance of sub-module lb_line_delay (IMG_WIDTH x 8 storage, write/read at col on in_valid).

Verification
REQ-029 SHALL cover: 4x4 frame of pixels 0..15 with continuous valid -> 4 windows, first = {0,1,2,4,5,6,8,9,10} one cycle after pixel 10, last = {5,6,7,9,10,11,13,14,15}.
REQ-030 SHALL cover: the same frame with in_valid=0 gaps of 1-3 cycles -> identical window sequence, and frame_done coincident with the 4th window.
REQ-031 SHALL cover: in_sof after pixel 9, then a full new frame 100..115 -> no frame_done for the aborted frame, and first window {100,101,102,104,105,106,108,109,110}.
REQ-032 SHALL cover: rst pulsed after pixel 12 -> outputs 0 immediately, and the next frame's windows are correct without in_sof.
REQ-033 SHALL cover: LINE_BUFFER_OUT_REG_EN defined -> scenario REQ-029 with every output delayed one extra cycle.
REQ-034 SHALL cover: IMG_WIDTH=5, IMG_HEIGHT=3 -> exactly 3 windows, frame_done after pixel 14, and back-to-back frames with no idle cycle.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg -- shared definitions for the line buffer and the convolution stage.
//
// Contents:
//   PIX_W, KSIZE, WIN_W : pixel width, kernel size and packed window width
//   lb_state_t          : line buffer fill/stream state
//   win_idx(r, c)       : LSB position of window element (r,c) inside a packed window
package conv_pkg;

    localparam int PIX_W = 8;
    localparam int KSIZE = 3;
    localparam int WIN_W = KSIZE * KSIZE * PIX_W;

    // FILL: fewer than two complete lines are stored, no window can be valid.
    // STREAM: rows 0 and 1 of the window come from the line delays.
    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } lb_state_t;

    // Element (r,c) sits at bits [win_idx(r,c) +: PIX_W]; p00 is the LSB byte.
    function automatic int win_idx(input int r, input int c);
        return (KSIZE * r + c) * PIX_W;
    endfunction

endpackage

// File: rtl/line_buffer_3x3_if.sv
// line_buffer_3x3_if -- pixel stream in, 3x3 window stream out.
//
// Handshake: in_valid alone qualifies in_pix and in_sof; there is no ready,
// every cycle with in_valid=1 transfers one pixel. win_valid qualifies win for
// exactly one cycle; frame_done pulses for one cycle with the last window.
//
// Signals:
//   in_valid, in_sof, in_pix  : source -> line buffer
//   win, win_valid, frame_done: line buffer -> sink
//   dbg_state                 : current fill/stream state (observation only)
// Modports: master (pixel source / window sink), slave (line buffer).
interface line_buffer_3x3_if;
    import conv_pkg::*;

    logic               in_valid;
    logic               in_sof;
    logic [PIX_W-1:0]   in_pix;
    logic [WIN_W-1:0]   win;
    logic               win_valid;
    logic               frame_done;
    lb_state_t          dbg_state;

    modport master (
        output in_valid, in_sof, in_pix,
        input  win, win_valid, frame_done, dbg_state
    );

    modport slave (
        input  in_valid, in_sof, in_pix,
        output win, win_valid, frame_done, dbg_state
    );

endinterface

// File: rtl/lb_line_delay.sv
// lb_line_delay -- one image line of pixel storage addressed by column.
//
// Ports:
//   clk     : clock
//   we      : write wr_data at addr on the rising edge
//   addr    : column index
//   wr_data : pixel written
//   rd_data : combinational read of addr (returns the value before this cycle's write)
//
// Storage is intentionally not reset; the line buffer refills it before use.
module lb_line_delay #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/line_buffer_3x3.sv
// line_buffer_3x3 -- turns a raster pixel stream into 3x3 neighbourhood windows.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : line_buffer_3x3_if.slave (in_valid/in_sof/in_pix in,
//          win/win_valid/frame_done/dbg_state out)
//
// Parameters: IMG_WIDTH, IMG_HEIGHT (3..1024).
// Build option: define LINE_BUFFER_OUT_REG_EN to add one output register stage
// on win, win_valid and frame_done (2-cycle latency instead of 1).
//
// Two cascaded line delays hold rows row-1 and row-2 at each column. Every
// accepted pixel shifts a 3x3 register left and appends {row-2, row-1, new}
// as the right column. The published window register only loads when the
// shifted window is complete and inside one line, so win holds between windows.
module line_buffer_3x3
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 4
) (
    input  logic              clk,
    input  logic              rst,
    line_buffer_3x3_if.slave  bus
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]    col, col_e;
    logic [RW-1:0]    row, row_e;
    lb_state_t        state, state_e;
    logic             col_last, row_last, fill_done, win_ok;
    logic [PIX_W-1:0] line1_rd, line0_rd;
    logic [WIN_W-1:0] sh, sh_next;
    logic [WIN_W-1:0] win_c;
    logic             win_valid_c, frame_done_c;

    // A start-of-frame pixel overrides the counters: it is (0,0) in FILL.
    always_comb begin
        col_e   = col;
        row_e   = row;
        state_e = state;
        if (bus.in_sof) begin
            col_e   = '0;
            row_e   = '0;
            state_e = FILL;
        end
    end

    assign col_last  = (col_e == COL_LAST);
    assign row_last  = (row_e == ROW_LAST);
    assign fill_done = (row_e == RW'(1)) && col_last;
    // Columns 0 and 1 of a line would pull in pixels from the previous line.
    assign win_ok    = (state_e == STREAM) && (col_e >= CW'(2));

    // line1 holds row-1; its old contents cascade into line0 as row-2.
    lb_line_delay #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_line1 (
        .clk     (clk),
        .we      (bus.in_valid),
        .addr    (col_e),
        .wr_data (bus.in_pix),
        .rd_data (line1_rd)
    );

    lb_line_delay #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_line0 (
        .clk     (clk),
        .we      (bus.in_valid),
        .addr    (col_e),
        .wr_data (line1_rd),
        .rd_data (line0_rd)
    );

    always_comb begin
        sh_next = sh;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
                sh_next[win_idx(r, c) +: PIX_W] = sh[win_idx(r, c + 1) +: PIX_W];
            end
        end
        sh_next[win_idx(0, 2) +: PIX_W] = line0_rd;
        sh_next[win_idx(1, 2) +: PIX_W] = line1_rd;
        sh_next[win_idx(2, 2) +: PIX_W] = bus.in_pix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            state        <= FILL;
            sh           <= '0;
            win_c        <= '0;
            win_valid_c  <= 1'b0;
            frame_done_c <= 1'b0;
        end else begin
            win_valid_c  <= 1'b0;
            frame_done_c <= 1'b0;
            if (bus.in_valid) begin
                sh    <= sh_next;
                state <= state_e;
                row   <= row_e;
                col   <= col_e + CW'(1);
                if (win_ok) begin
                    win_c       <= sh_next;
                    win_valid_c <= 1'b1;
                end
                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row          <= '0;
                        state        <= FILL;
                        frame_done_c <= 1'b1;
                    end else begin
                        row <= row_e + RW'(1);
                        if (fill_done) begin
                            state <= STREAM;
                        end
                    end
                end
            end
        end
    end

    assign bus.dbg_state = state;

`ifdef LINE_BUFFER_OUT_REG_EN
    logic [WIN_W-1:0] win_q;
    logic             win_valid_q, frame_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_q        <= win_c;
            win_valid_q  <= win_valid_c;
            frame_done_q <= frame_done_c;
        end
    end

    assign bus.win        = win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
`else
    assign bus.win        = win_c;
    assign bus.win_valid  = win_valid_c;
    assign bus.frame_done = frame_done_c;
`endif

endmodule

// File: tb/tb_line_buffer_3x3.sv
// tb_line_buffer_3x3 -- directed bench for line_buffer_3x3.
// DUT a: 4x4 image. DUT b: 5x3 image. Latency follows LINE_BUFFER_OUT_REG_EN.
module tb_line_buffer_3x3;
    import conv_pkg::*;

`ifdef LINE_BUFFER_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;

    line_buffer_3x3_if bus_a ();
    line_buffer_3x3_if bus_b ();

    line_buffer_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    line_buffer_3x3 #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- monitor ----------------
    int               neg_cnt = 0;
    logic [WIN_W-1:0] wq_a[$], wq_b[$];
    int               wn_a[$], wn_b[$], fd_a[$], fd_b[$];
    logic [WIN_W-1:0] last_win_a = '0, last_win_b = '0;
    int               hold_err = 0;
    logic [WIN_W-1:0] exp_q[$];

    always @(negedge clk) begin
        neg_cnt++;
        if (bus_a.win_valid === 1'b1) begin wq_a.push_back(bus_a.win); wn_a.push_back(neg_cnt); end
        if (bus_b.win_valid === 1'b1) begin wq_b.push_back(bus_b.win); wn_b.push_back(neg_cnt); end
        if (bus_a.frame_done === 1'b1) fd_a.push_back(neg_cnt);
        if (bus_b.frame_done === 1'b1) fd_b.push_back(neg_cnt);
        if (rst === 1'b0) begin
            if (bus_a.win_valid !== 1'b1 && bus_a.win !== last_win_a) hold_err++;
            if (bus_b.win_valid !== 1'b1 && bus_b.win !== last_win_b) hold_err++;
        end
        last_win_a = bus_a.win;
        last_win_b = bus_b.win;
    end

    // ---------------- drivers ----------------
    function automatic logic [WIN_W-1:0] pack9(input int p00, p01, p02, p10, p11, p12,
                                               p20, p21, p22);
        return {8'(p22), 8'(p21), 8'(p20), 8'(p12), 8'(p11), 8'(p10),
                8'(p02), 8'(p01), 8'(p00)};
    endfunction

    // acc is the monitor index at which this pixel's 1-cycle result becomes visible minus 1.
    task automatic drive(input int sel, input int pix, input logic sof, output int acc);
        @(negedge clk);
        #1;
        bus_a.in_valid = (sel == 0);
        bus_a.in_sof   = sof;
        bus_a.in_pix   = 8'(pix);
        bus_b.in_valid = (sel == 1);
        bus_b.in_sof   = sof;
        bus_b.in_pix   = 8'(pix);
        acc = neg_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            bus_a.in_valid = 1'b0;
            bus_a.in_sof   = 1'b0;
            bus_b.in_valid = 1'b0;
            bus_b.in_sof   = 1'b0;
        end
    endtask

    task automatic clear_mon();
        wq_a.delete(); wn_a.delete(); fd_a.delete();
        wq_b.delete(); wn_b.delete(); fd_b.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_sof = 1'b0; bus_a.in_pix = '0;
        bus_b.in_valid = 1'b0; bus_b.in_sof = 1'b0; bus_b.in_pix = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus_a.win !== '0 || bus_a.win_valid !== 1'b0 || bus_a.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: win=%h wv=%b fd=%b, required all zero",
                     bus_a.win, bus_a.win_valid, bus_a.frame_done);
        end
        checks++;
        if (bus_a.dbg_state !== FILL || bus_b.dbg_state !== FILL) begin
            errors++;
            $display("FAIL reset_state: a=%0d b=%0d, required FILL", bus_a.dbg_state, bus_b.dbg_state);
        end
        checks++;
        if (bus_b.win !== '0 || bus_b.win_valid !== 1'b0 || bus_b.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: win=%h wv=%b fd=%b, required all zero",
                     bus_b.win, bus_b.win_valid, bus_b.frame_done);
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_continuous();
        int acc[16];
        clear_mon();
        exp_q = {pack9(0, 1, 2, 4, 5, 6, 8, 9, 10), pack9(1, 2, 3, 5, 6, 7, 9, 10, 11),
                 pack9(4, 5, 6, 8, 9, 10, 12, 13, 14), pack9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
        for (int i = 0; i < 16; i++) drive(0, i, 1'b0, acc[i]);
        idle(LAT + 3);
        checks++;
        if (wq_a.size() != 4) begin errors++; $display("FAIL cont_count: got %0d windows, required 4", wq_a.size()); end
        for (int k = 0; k < 4 && k < wq_a.size(); k++) begin
            checks++;
            if (wq_a[k] !== exp_q[k]) begin errors++; $display("FAIL cont_win%0d: got %h required %h", k, wq_a[k], exp_q[k]); end
        end
        if (wn_a.size() == 4) begin
            checks++;
            if (wn_a[0] != acc[10] + LAT) begin errors++; $display("FAIL cont_first_lat: at %0d required %0d", wn_a[0], acc[10] + LAT); end
            checks++;
            if (wn_a[3] != acc[15] + LAT) begin errors++; $display("FAIL cont_last_lat: at %0d required %0d", wn_a[3], acc[15] + LAT); end
        end
        checks++;
        if (fd_a.size() != 1) begin errors++; $display("FAIL cont_fd_count: got %0d required 1", fd_a.size()); end
        else begin
            checks++;
            if (fd_a[0] != acc[15] + LAT) begin errors++; $display("FAIL cont_fd_time: at %0d required %0d", fd_a[0], acc[15] + LAT); end
        end
    endtask

    task automatic test_gaps();
        int acc[16];
        clear_mon();
        exp_q = {pack9(0, 1, 2, 4, 5, 6, 8, 9, 10), pack9(1, 2, 3, 5, 6, 7, 9, 10, 11),
                 pack9(4, 5, 6, 8, 9, 10, 12, 13, 14), pack9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
        for (int i = 0; i < 16; i++) begin
            idle((i % 3) + 1);
            drive(0, i, 1'b0, acc[i]);
        end
        idle(LAT + 3);
        checks++;
        if (wq_a.size() != 4) begin errors++; $display("FAIL gap_count: got %0d windows, required 4", wq_a.size()); end
        for (int k = 0; k < 4 && k < wq_a.size(); k++) begin
            checks++;
            if (wq_a[k] !== exp_q[k]) begin errors++; $display("FAIL gap_win%0d: got %h required %h", k, wq_a[k], exp_q[k]); end
        end
        checks++;
        if (fd_a.size() != 1 || wn_a.size() != 4) begin
            errors++; $display("FAIL gap_fd_count: fd=%0d win=%0d required 1 and 4", fd_a.size(), wn_a.size());
        end else begin
            checks++;
            if (fd_a[0] != wn_a[3]) begin errors++; $display("FAIL gap_fd_coincident: fd at %0d window4 at %0d", fd_a[0], wn_a[3]); end
            checks++;
            if (wn_a[0] != acc[10] + LAT) begin errors++; $display("FAIL gap_first_lat: at %0d required %0d", wn_a[0], acc[10] + LAT); end
        end
    endtask

    task automatic test_abort();
        int acc;
        int accn[16];
        clear_mon();
        for (int i = 0; i < 10; i++) drive(0, i, (i == 0), acc);
        for (int i = 0; i < 16; i++) drive(0, 100 + i, (i == 0), accn[i]);
        idle(LAT + 3);
        exp_q = {pack9(100, 101, 102, 104, 105, 106, 108, 109, 110),
                 pack9(101, 102, 103, 105, 106, 107, 109, 110, 111),
                 pack9(104, 105, 106, 108, 109, 110, 112, 113, 114),
                 pack9(105, 106, 107, 109, 110, 111, 113, 114, 115)};
        checks++;
        if (wq_a.size() != 4) begin errors++; $display("FAIL abort_count: got %0d windows, required 4", wq_a.size()); end
        for (int k = 0; k < 4 && k < wq_a.size(); k++) begin
            checks++;
            if (wq_a[k] !== exp_q[k]) begin errors++; $display("FAIL abort_win%0d: got %h required %h", k, wq_a[k], exp_q[k]); end
        end
        checks++;
        if (fd_a.size() != 1) begin errors++; $display("FAIL abort_fd_count: got %0d required 1", fd_a.size()); end
        else begin
            checks++;
            if (fd_a[0] != accn[15] + LAT) begin errors++; $display("FAIL abort_fd_time: at %0d required %0d", fd_a[0], accn[15] + LAT); end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        clear_mon();
        for (int i = 0; i <= 12; i++) drive(0, i, (i == 0), acc);
        @(negedge clk);
        checks++;
        if (bus_a.dbg_state !== STREAM) begin errors++; $display("FAIL mid_state: got %0d required STREAM", bus_a.dbg_state); end
        #1;
        bus_a.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (wq_a.size() != 2) begin errors++; $display("FAIL mid_prewin: got %0d windows, required 2", wq_a.size()); end
        checks++;
        if (bus_a.win !== '0 || bus_a.win_valid !== 1'b0 || bus_a.frame_done !== 1'b0 || bus_a.dbg_state !== FILL) begin
            errors++;
            $display("FAIL mid_rst_outputs: win=%h wv=%b fd=%b st=%0d required zero/FILL",
                     bus_a.win, bus_a.win_valid, bus_a.frame_done, bus_a.dbg_state);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        for (int i = 0; i < 16; i++) drive(0, 50 + i, 1'b0, acc);
        idle(LAT + 3);
        exp_q = {pack9(50, 51, 52, 54, 55, 56, 58, 59, 60), pack9(51, 52, 53, 55, 56, 57, 59, 60, 61),
                 pack9(54, 55, 56, 58, 59, 60, 62, 63, 64), pack9(55, 56, 57, 59, 60, 61, 63, 64, 65)};
        checks++;
        if (wq_a.size() != 4 || fd_a.size() != 1) begin
            errors++; $display("FAIL mid_after_count: win=%0d fd=%0d required 4 and 1", wq_a.size(), fd_a.size());
        end
        for (int k = 0; k < 4 && k < wq_a.size(); k++) begin
            checks++;
            if (wq_a[k] !== exp_q[k]) begin errors++; $display("FAIL mid_win%0d: got %h required %h", k, wq_a[k], exp_q[k]); end
        end
    endtask

    task automatic test_back_to_back();
        int acc[30];
        clear_mon();
        for (int i = 0; i < 15; i++) drive(1, i, 1'b0, acc[i]);
        for (int i = 0; i < 15; i++) drive(1, 20 + i, 1'b0, acc[15 + i]);
        idle(LAT + 3);
        exp_q = {pack9(0, 1, 2, 5, 6, 7, 10, 11, 12), pack9(1, 2, 3, 6, 7, 8, 11, 12, 13),
                 pack9(2, 3, 4, 7, 8, 9, 12, 13, 14),
                 pack9(20, 21, 22, 25, 26, 27, 30, 31, 32), pack9(21, 22, 23, 26, 27, 28, 31, 32, 33),
                 pack9(22, 23, 24, 27, 28, 29, 32, 33, 34)};
        checks++;
        if (wq_b.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d windows, required 6", wq_b.size()); end
        for (int k = 0; k < 6 && k < wq_b.size(); k++) begin
            checks++;
            if (wq_b[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_win%0d: got %h required %h", k, wq_b[k], exp_q[k]); end
        end
        checks++;
        if (fd_b.size() != 2) begin errors++; $display("FAIL b2b_fd_count: got %0d required 2", fd_b.size()); end
        else begin
            checks++;
            if (fd_b[0] != acc[14] + LAT) begin errors++; $display("FAIL b2b_fd0: at %0d required %0d", fd_b[0], acc[14] + LAT); end
            checks++;
            if (fd_b[1] != acc[29] + LAT) begin errors++; $display("FAIL b2b_fd1: at %0d required %0d", fd_b[1], acc[29] + LAT); end
        end
        checks++;
        if (wq_a.size() != 0) begin errors++; $display("FAIL b2b_idle_a: got %0d windows on idle DUT, required 0", wq_a.size()); end
    endtask

    task automatic test_hold();
        checks++;
        if (hold_err != 0) begin errors++; $display("FAIL win_hold: %0d changes while win_valid=0, required 0", hold_err); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
